// File: rtl/load_value_table.sv
// Last-value load predictor: per-PC value table with saturating confidence,
// single outstanding prediction, verify/recover handshake with the pipeline.
module load_value_table #(
  parameter int ENTRIES     = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lu_valid,
  input  logic [31:0]           lu_pc,
  output logic                  pred_valid,
  output logic [DATA_WIDTH-1:0] pred_data,
  output logic                  busy,
  input  logic                  train_valid,
  input  logic [31:0]           train_pc,
  input  logic [DATA_WIDTH-1:0] train_data,
  output logic                  pred_correct,
  output logic                  pred_wrong,
  output logic                  recover,
  input  logic                  recovery_done,
  input  logic                  flush,
  output logic [15:0]           pred_count,
  output logic [15:0]           wrong_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
  localparam logic [CONF_BITS-1:0] THRESH   = CONF_BITS'(CONF_THRESH);

  logic                  valid_q [ENTRIES];
  logic [TAG_W-1:0]      tag_q   [ENTRIES];
  logic [DATA_WIDTH-1:0] data_q  [ENTRIES];
  logic [CONF_BITS-1:0]  conf_q  [ENTRIES];

  logic [1:0]            state_q, state_d;
  logic [31:0]           lpc_q, lpc_d;
  logic [DATA_WIDTH-1:0] lval_q, lval_d;
  logic                  pv_q, pv_d;
  logic [DATA_WIDTH-1:0] pd_q, pd_d;
  logic                  pc_q, pc_d;
  logic                  pw_q, pw_d;
  logic [15:0]           pcnt_q, pcnt_d;
  logic [15:0]           wcnt_q, wcnt_d;

  logic [IDX_W-1:0] l_idx, t_idx;
  logic [TAG_W-1:0] l_tag, t_tag;
  logic             l_hit, t_hit, t_eq, l_pred;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lu_pc[1:0], train_pc[1:0]};

  assign l_idx  = lu_pc[IDX_W+1:2];
  assign l_tag  = lu_pc[31:IDX_W+2];
  assign t_idx  = train_pc[IDX_W+1:2];
  assign t_tag  = train_pc[31:IDX_W+2];
  assign l_hit  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign t_hit  = valid_q[t_idx] && (tag_q[t_idx] == t_tag);
  assign t_eq   = (data_q[t_idx] == train_data);
  assign l_pred = l_hit && (conf_q[l_idx] >= THRESH);

  // Table training on every returning load; lookups see pre-update contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
        conf_q[i]  <= '0;
      end
    end else if (train_valid) begin
      if (t_hit && t_eq) begin
        if (conf_q[t_idx] != CONF_MAX) conf_q[t_idx] <= conf_q[t_idx] + 1'b1;
      end else begin
        valid_q[t_idx] <= 1'b1;
        tag_q[t_idx]   <= t_tag;
        data_q[t_idx]  <= train_data;
        conf_q[t_idx]  <= '0;
      end
    end
  end

  // Prediction FSM next-state, pulse and counter logic.
  always_comb begin
    state_d = state_q;
    lpc_d   = lpc_q;
    lval_d  = lval_q;
    pv_d    = 1'b0;
    pd_d    = pd_q;
    pc_d    = 1'b0;
    pw_d    = 1'b0;
    pcnt_d  = pcnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (lu_valid && l_pred) begin
          pv_d    = 1'b1;
          pd_d    = data_q[l_idx];
          lpc_d   = lu_pc;
          lval_d  = data_q[l_idx];
          state_d = WAIT;
          if (pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
        end
      end
      WAIT: begin
        // flush outranks a same-cycle verdict
        if (flush) begin
          state_d = IDLE;
        end else if (train_valid && (train_pc == lpc_q)) begin
          if (train_data == lval_q) begin
            pc_d    = 1'b1;
            state_d = IDLE;
          end else begin
            pw_d    = 1'b1;
            state_d = RECOVER;
            if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
          end
        end
      end
      RECOVER: begin
        if (recovery_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lpc_q   <= '0;
      lval_q  <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      pc_q    <= 1'b0;
      pw_q    <= 1'b0;
      pcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lpc_q   <= lpc_d;
      lval_q  <= lval_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      pc_q    <= pc_d;
      pw_q    <= pw_d;
      pcnt_q  <= pcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign pred_valid   = pv_q;
  assign pred_data    = pd_q;
  assign pred_correct = pc_q;
  assign pred_wrong   = pw_q;
  assign recover      = (state_q == RECOVER);
  assign busy         = (state_q != IDLE);
  assign pred_count   = pcnt_q;
  assign wrong_count  = wcnt_q;

endmodule
